// File: rtl/kreuzung_ctrl.sv
// kreuzung_ctrl: two-road intersection phase sequencer with a debounced pedestrian request key
module kreuzung_ctrl #(
    parameter int TICK_DIV   = 25000000,
    parameter int DB_CYCLES  = 500000,
    parameter int T_MAIN_MIN = 10,
    parameter int T_YELLOW   = 4,
    parameter int T_ALLRED   = 2,
    parameter int T_REDYEL   = 2,
    parameter int T_SIDE     = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key0,
    output logic [7:0] led,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        MAIN_GREEN, MAIN_YELLOW, ALLRED_A, SIDE_REDYEL,
        SIDE_GREEN, SIDE_YELLOW, ALLRED_B, MAIN_REDYEL
    } state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES) + 1;
    logic          r_sync1, r_sync2, r_db_level, r_press, r_req;
    logic [DW-1:0] r_db_cnt;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_pcnt;
    logic [6:0]    r_lights;
    state_t        r_state, w_next;
    logic          w_tick, w_exit, w_fall;
    logic [7:0]    w_last;
    // bit order: walk, side G/Y/R, main G/Y/R
    function automatic logic [6:0] lights(input state_t s);
        return s == MAIN_GREEN  ? 7'h0C :
               s == MAIN_YELLOW ? 7'h0A :
               s == SIDE_REDYEL ? 7'h19 :
               s == SIDE_GREEN  ? 7'h61 :
               s == SIDE_YELLOW ? 7'h11 :
               s == MAIN_REDYEL ? 7'h0B : 7'h09;
    endfunction
    assign w_tick = r_pre == PW'(TICK_DIV - 1);
    assign w_fall = r_db_level && !r_sync2 && r_db_cnt == DW'(DB_CYCLES - 1);
    always_comb begin
        w_last = r_state == MAIN_GREEN ? 8'(T_MAIN_MIN - 1) :
                 (r_state == MAIN_YELLOW || r_state == SIDE_YELLOW) ? 8'(T_YELLOW - 1) :
                 (r_state == ALLRED_A || r_state == ALLRED_B) ? 8'(T_ALLRED - 1) :
                 (r_state == SIDE_REDYEL || r_state == MAIN_REDYEL) ? 8'(T_REDYEL - 1) :
                 8'(T_SIDE - 1);
    end
    // timed states never run past their last count, so >= matches == there
    assign w_exit = w_tick && r_pcnt >= w_last && (r_state != MAIN_GREEN || r_req);
    assign w_next = w_exit ? state_t'(r_state + 3'd1) : r_state;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1 <= key0;
            r_sync2 <= r_sync1;
            r_press <= w_fall;
            if (r_sync2 == r_db_level)
                r_db_cnt <= '0;
            else if (r_db_cnt == DW'(DB_CYCLES - 1)) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else
                r_db_cnt <= r_db_cnt + 1'b1;
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= MAIN_GREEN;
            r_pre    <= '0;
            r_pcnt   <= '0;
            r_req    <= 1'b0;
            r_lights <= lights(MAIN_GREEN);
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_state  <= w_next;
            r_lights <= lights(w_next);
            r_pcnt   <= w_next != r_state ? '0 :
                        (w_tick && r_pcnt != 8'hFF) ? r_pcnt + 1'b1 : r_pcnt;
            // entering SIDE_REDYEL clears the request even against a coincident press
            r_req    <= (w_next == SIDE_REDYEL && r_state != SIDE_REDYEL) ? 1'b0 :
                        (r_press && r_state != SIDE_GREEN) ? 1'b1 : r_req;
        end
    end
    assign led   = {r_req, r_lights};
    assign phase = r_state;
endmodule

// File: doc/kreuzung_ctrl.md
# kreuzung_ctrl

Phase sequencer for a two-road intersection (main road, side road) with a pedestrian request key. It divides the board clock into a slow phase tick and runs an eight-state light schedule. The main road stays green until a debounced key press is latched and the minimum main-green time has elapsed. It drives the board LEDs directly and sits at top level beside the clock divider logic.

## Interface
- TICK_DIV, 25000000: CLOCK_50 cycles per phase tick (0.5 s); range 2..2^26.
- DB_CYCLES, 500000: key must be stable this many cycles (10 ms) to register a press; range 1..2^20.
- T_MAIN_MIN, 10: minimum main-green ticks; 1..255.
- T_YELLOW, 4: yellow ticks, both roads; 1..255.
- T_ALLRED, 2: all-red ticks; 1..255.
- T_REDYEL, 2: red+yellow ticks, both roads; 1..255.
- T_SIDE, 8: side-green and walk ticks; 1..255.
- CLOCK_50  in  1  board clock; single clock domain.
- reset  in  1  synchronous, active-high.
- key0  in  1  pedestrian request key, active-low, asynchronous to CLOCK_50.
- led  out  8  [0] main red, [1] main yellow, [2] main green, [3] side red, [4] side yellow, [5] side green, [6] walk, [7] request pending.
- phase  out  3  current state encoding, for debug.

## Operation
- Key path: two-flop synchronizer, then debounce counter. The debounced level changes only after DB_CYCLES consecutive equal samples. A 1→0 transition of the debounced level is one press, a single-cycle pulse.
- req_pending: set by a press in any state except SIDE_GREEN. Cleared on the cycle the FSM enters SIDE_REDYEL. If a press and the clear occur in the same cycle, the clear wins. Drives led[7].
- Tick: a prescaler counts 0..TICK_DIV-1. tick=1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Phase counter: 8 bits. It increments on tick. It is zeroed on every state change.
- A timed state with duration T exits on the tick where phase counter == T-1.
- States, with phase encoding, outputs, and exit rule:
  - 0 MAIN_GREEN: main G, side R. Exit to MAIN_YELLOW on a tick where req_pending=1 and phase counter ≥ T_MAIN_MIN-1. The phase counter saturates at 255.
  - 1 MAIN_YELLOW: main Y, side R. Lasts T_YELLOW, then ALLRED_A.
  - 2 ALLRED_A: main R, side R. Lasts T_ALLRED, then SIDE_REDYEL.
  - 3 SIDE_REDYEL: main R, side R+Y. Lasts T_REDYEL, then SIDE_GREEN.
  - 4 SIDE_GREEN: main R, side G, walk=1. Lasts T_SIDE, then SIDE_YELLOW.
  - 5 SIDE_YELLOW: main R, side Y. Lasts T_YELLOW, then ALLRED_B.
  - 6 ALLRED_B: main R, side R. Lasts T_ALLRED, then MAIN_REDYEL.
  - 7 MAIN_REDYEL: main R+Y, side R. Lasts T_REDYEL, then MAIN_GREEN.
- Outputs are registered and decoded from the state register. Exactly one main and one side light combination is valid at a time. Main green and side green are never lit together.

## Timing
- Reset, synchronous: state=MAIN_GREEN, prescaler=0, phase counter=0, req_pending=0, synchronizer and debounce state at 1 (released).
- Output values at reset: led=8'b0000_1100, i.e. main G and side R; phase=0.
- Reset asserted mid-sequence: on the next clock edge the block is in the full reset state regardless of phase. The minimum main-green time restarts.
- Key press latency: 2 sync cycles + DB_CYCLES + 1 cycle until req_pending=1 appears on led[7].
- State change occurs on the clock edge after the tick cycle that satisfies the exit rule. led and phase update on that same edge.
- If a press lands while in MAIN_GREEN with phase counter already ≥ T_MAIN_MIN-1, MAIN_YELLOW is entered at the first tick after req_pending=1.
- Full side-road service after leaving MAIN_GREEN: 2·T_YELLOW + 2·T_ALLRED + 2·T_REDYEL + T_SIDE ticks.

## Test plan
Use TICK_DIV=4, DB_CYCLES=3, T_MAIN_MIN=3, T_YELLOW=2, T_ALLRED=1, T_REDYEL=1, T_SIDE=2 in all scenarios.

- Reset check: hold reset 5 cycles → led=0x0C, phase=0. With key0 held high for 200 cycles, the state stays MAIN_GREEN.
- Single press: hold key0 low 10 cycles at t=0 → led[7]=1 at cycle 6. Phases then run 1,2,3,4,5,6,7,0 with dwell 2,1,1,2,2,1,1 ticks. led[6]=1 only in phase 4. led[7] clears on entry to phase 3.
- Early press: press at tick 0 of MAIN_GREEN → MAIN_YELLOW is not entered before the tick where phase counter=2.
- Bounce: key0 toggling with pulses ≤2 cycles wide for 50 cycles → req_pending stays 0.
- Press in SIDE_GREEN → ignored; the FSM returns to MAIN_GREEN with led[7]=0. A press in SIDE_YELLOW → latched, so a second side cycle follows after T_MAIN_MIN.
- Reset asserted in SIDE_GREEN → next edge gives led=0x0C, phase=0, led[7]=0.
